// File: rtl/trdb_pkg.sv
// trdb_pkg: register offsets, CFG/STATUS bit indices and flush FSM states for trdb_regfile
package trdb_pkg;
  localparam int unsigned CFG_OFF = 32'h00;
  localparam int unsigned CTRL_OFF = 32'h04;
  localparam int unsigned STATUS_OFF = 32'h08;
  localparam int unsigned DUMP_OFF = 32'h0C;
  localparam int unsigned FILT_LO_OFF = 32'h10;
  localparam int unsigned FILT_HI_OFF = 32'h14;
  localparam int unsigned FILT_STRIDE = 8;
  localparam int unsigned CFG_TRACE_EN_BIT = 0;
  localparam int unsigned CFG_FILT_EN_LSB = 8;
  localparam int unsigned ST_BUSY_BIT = 0;
  localparam int unsigned ST_OVF_BIT = 1;
  localparam int unsigned ST_EMPTY_BIT = 2;
  localparam int unsigned ST_FULL_BIT = 3;
  localparam int unsigned ST_CNT_LSB = 8;
  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} flush_state_e;
  function automatic int unsigned filt_lo_off(input int i);
    return FILT_LO_OFF + FILT_STRIDE * i;
  endfunction
  function automatic int unsigned filt_hi_off(input int i);
    return FILT_HI_OFF + FILT_STRIDE * i;
  endfunction
endpackage

// File: rtl/trdb_fifo.sv
// trdb_fifo: synchronous FIFO; a push while full is accepted only alongside a pop
// ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
// pop_i/data_o read side (data_o is 0 when empty); full_o/empty_o/count_o occupancy
module trdb_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       pop_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o = empty_o ? '0 : mem_q[rptr_q];
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wptr_q] = data_i;
    wptr_d = do_push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = do_pop ? rptr_q + PW'(1) : rptr_q;
    count_d = (do_push && !do_pop) ? count_q + CW'(1) :
              (do_pop && !do_push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/trdb_regfile.sv
// trdb_regfile: trace debug register file with address filters, flush handshake and dump FIFO
// ports: clk_i/rst_ni clock and async active-low reset; per_* zero-wait peripheral bus;
// trace_enable_o/filter_* configuration outputs; flush_stream_o/flush_confirm_i flush
// handshake; dump_data_o/dump_valid_o/dump_ready_i dump stream
module trdb_regfile
  import trdb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_FILTERS = 2,
  parameter int unsigned DUMP_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             per_valid_i,
  input  logic                             per_we_i,
  input  logic [APB_ADDR_WIDTH-1:0]        per_addr_i,
  input  logic [31:0]                      per_wdata_i,
  output logic [31:0]                      per_rdata_o,
  output logic                             per_ready_o,
  output logic                             trace_enable_o,
  output logic [NUM_FILTERS-1:0]           filter_en_o,
  output logic [NUM_FILTERS-1:0][31:0]     filter_lo_o,
  output logic [NUM_FILTERS-1:0][31:0]     filter_hi_o,
  output logic                             flush_stream_o,
  input  logic                             flush_confirm_i,
  output logic [31:0]                      dump_data_o,
  output logic                             dump_valid_o,
  input  logic                             dump_ready_i
);
  localparam int unsigned AW = APB_ADDR_WIDTH;
  localparam int unsigned CW = $clog2(DUMP_DEPTH) + 1;
  logic [31:0] cfg_q, cfg_d;
  logic [NUM_FILTERS-1:0][31:0] lo_q, lo_d, hi_q, hi_d;
  flush_state_e state_q, state_d;
  logic ovf_q, ovf_d;
  logic [AW-1:0] addr;
  logic rd, wr, wr_ctrl, wr_status, push, pop, full, empty, busy;
  logic [CW-1:0] count;
  logic [31:0] status, rdata;
  // byte lanes are not decoded; masking keeps every address bit consumed
  assign addr = per_addr_i & ~AW'(3);
  // reads are gated by reset so every data output is 0 while rst_ni is low
  assign rd = per_valid_i & ~per_we_i & rst_ni;
  assign wr = per_valid_i & per_we_i;
  assign wr_ctrl = wr && addr == AW'(CTRL_OFF);
  assign wr_status = wr && addr == AW'(STATUS_OFF);
  assign push = wr && addr == AW'(DUMP_OFF);
  assign pop = dump_valid_o & dump_ready_i;
  assign busy = state_q == FLUSH;
  assign per_ready_o = 1'b1;
  assign per_rdata_o = rd ? rdata : '0;
  assign trace_enable_o = cfg_q[CFG_TRACE_EN_BIT];
  assign filter_en_o = cfg_q[CFG_FILT_EN_LSB +: NUM_FILTERS];
  assign filter_lo_o = lo_q;
  assign filter_hi_o = hi_q;
  assign flush_stream_o = busy;
  assign dump_valid_o = ~empty;
  trdb_fifo #(.DATA_WIDTH(32), .DEPTH(DUMP_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (per_wdata_i),
    .pop_i   (pop),
    .data_o  (dump_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    status = '0;
    status[ST_BUSY_BIT] = busy;
    status[ST_OVF_BIT] = ovf_q;
    status[ST_EMPTY_BIT] = empty;
    status[ST_FULL_BIT] = full;
    status[ST_CNT_LSB +: 8] = 8'(count);
    rdata = '0;
    if (addr == AW'(CFG_OFF)) rdata = cfg_q;
    if (addr == AW'(CTRL_OFF)) rdata = {31'b0, busy};
    if (addr == AW'(STATUS_OFF)) rdata = status;
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      if (addr == AW'(filt_lo_off(i))) rdata = lo_q[i];
      if (addr == AW'(filt_hi_off(i))) rdata = hi_q[i];
    end
  end
  always_comb begin
    cfg_d = (wr && addr == AW'(CFG_OFF)) ? per_wdata_i : cfg_q;
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      lo_d[i] = (wr && addr == AW'(filt_lo_off(i))) ? per_wdata_i : lo_q[i];
      hi_d[i] = (wr && addr == AW'(filt_hi_off(i))) ? per_wdata_i : hi_q[i];
    end
    state_d = (state_q == IDLE) ? ((wr_ctrl && per_wdata_i[0]) ? FLUSH : IDLE) :
              (flush_confirm_i ? IDLE : FLUSH);
    // a dropped push sets overflow even when software clears it in the same cycle
    ovf_d = (push & full & ~pop) | (ovf_q & ~(wr_status & per_wdata_i[ST_OVF_BIT]));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      state_q <= IDLE;
      ovf_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      state_q <= state_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_trdb_regfile.sv
// tb_trdb_regfile: scoreboard bench for trdb_regfile; reads and dump words are checked by a monitor
module tb_trdb_regfile;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic per_valid_i, per_we_i;
  logic [11:0] per_addr_i;
  logic [31:0] per_wdata_i, per_rdata_o;
  logic per_ready_o, trace_enable_o;
  logic [1:0] filter_en_o;
  logic [1:0][31:0] filter_lo_o, filter_hi_o;
  logic flush_stream_o, flush_confirm_i;
  logic [31:0] dump_data_o;
  logic dump_valid_o, dump_ready_i;
  int errors = 0;
  int checks = 0;
  logic [31:0] rd_q[$];
  logic [31:0] dump_q[$];

  trdb_regfile #(.APB_ADDR_WIDTH(12), .NUM_FILTERS(2), .DUMP_DEPTH(4)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .per_valid_i     (per_valid_i),
    .per_we_i        (per_we_i),
    .per_addr_i      (per_addr_i),
    .per_wdata_i     (per_wdata_i),
    .per_rdata_o     (per_rdata_o),
    .per_ready_o     (per_ready_o),
    .trace_enable_o  (trace_enable_o),
    .filter_en_o     (filter_en_o),
    .filter_lo_o     (filter_lo_o),
    .filter_hi_o     (filter_hi_o),
    .flush_stream_o  (flush_stream_o),
    .flush_confirm_i (flush_confirm_i),
    .dump_data_o     (dump_data_o),
    .dump_valid_o    (dump_valid_o),
    .dump_ready_i    (dump_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents read data or a dump word
  always @(negedge clk_i) begin
    if (per_valid_i && !per_we_i && per_ready_o) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: unexpected read addr 0x%03h got 0x%08h", per_addr_i, per_rdata_o);
      end else chk($sformatf("rdata@%03h", per_addr_i), per_rdata_o, rd_q.pop_front());
    end
    if (dump_valid_o && dump_ready_i) begin
      if (dump_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump: unexpected word got 0x%08h", dump_data_o);
      end else chk("dump", dump_data_o, dump_q.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    per_valid_i = 1'b1;
    per_we_i = 1'b1;
    per_addr_i = a;
    per_wdata_i = d;
    cyc();
    per_valid_i = 1'b0;
    per_we_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    per_valid_i = 1'b1;
    per_we_i = 1'b0;
    per_addr_i = a;
    cyc();
    per_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    dump_ready_i = 1'b1;
    while (dump_valid_o && n < 20) begin
      cyc();
      n++;
    end
    dump_ready_i = 1'b0;
    chk("drain_done", 32'(dump_valid_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    per_valid_i = 1'b1;
    per_we_i = 1'b0;
    per_addr_i = 12'h008;
    per_wdata_i = '0;
    flush_confirm_i = 1'b0;
    dump_ready_i = 1'b0;
    rd_q.push_back(32'h0);
    #3;
    chk("rst_ready", 32'(per_ready_o), 32'd1);
    chk("rst_rdata", per_rdata_o, 32'd0);
    chk("rst_flush", 32'(flush_stream_o), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid_o), 32'd0);
    chk("rst_trace", 32'(trace_enable_o), 32'd0);
    @(negedge clk_i);
    #1;
    per_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    cyc();
    rd(12'h000, 32'h0);
    rd(12'h008, 32'h4);
    // configuration register and filter enables
    wr(12'h000, 32'h0000_0301);
    chk("trace_enable", 32'(trace_enable_o), 32'd1);
    chk("filter_en", 32'(filter_en_o), 32'd3);
    rd(12'h000, 32'h0000_0301);
    rd(12'h003, 32'h0000_0301);
    // filter bounds, unmapped and write-only reads
    wr(12'h018, 32'h8000_0000);
    wr(12'h01C, 32'h8000_FFFF);
    chk("filter_lo1", filter_lo_o[1], 32'h8000_0000);
    chk("filter_hi1", filter_hi_o[1], 32'h8000_FFFF);
    chk("filter_lo0", filter_lo_o[0], 32'h0);
    rd(12'h018, 32'h8000_0000);
    rd(12'h01C, 32'h8000_FFFF);
    rd(12'h040, 32'h0);
    rd(12'h00C, 32'h0);
    wr(12'h040, 32'hFFFF_FFFF);
    rd(12'h000, 32'h0000_0301);
    // flush handshake
    wr(12'h004, 32'h0);
    chk("flush_ctrl0", 32'(flush_stream_o), 32'd0);
    wr(12'h004, 32'h1);
    chk("flush_start", 32'(flush_stream_o), 32'd1);
    rd(12'h004, 32'h1);
    rd(12'h008, 32'h5);
    wr(12'h004, 32'h1);
    chk("flush_rewrite", 32'(flush_stream_o), 32'd1);
    flush_confirm_i = 1'b1;
    cyc();
    flush_confirm_i = 1'b0;
    chk("flush_done", 32'(flush_stream_o), 32'd0);
    rd(12'h008, 32'h4);
    flush_confirm_i = 1'b1;
    cyc();
    flush_confirm_i = 1'b0;
    chk("confirm_idle", 32'(flush_stream_o), 32'd0);
    // overflow: fifth word dropped
    for (int i = 0; i < 5; i++) begin
      if (i < 4) dump_q.push_back(32'hA0 + 32'(i));
      wr(12'h00C, 32'hA0 + 32'(i));
    end
    rd(12'h008, 32'h0000_040A);
    drain();
    rd(12'h008, 32'h6);
    wr(12'h008, 32'h2);
    rd(12'h008, 32'h4);
    // push while full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      dump_q.push_back(32'hB0 + 32'(i));
      wr(12'h00C, 32'hB0 + 32'(i));
    end
    dump_q.push_back(32'hB4);
    dump_ready_i = 1'b1;
    wr(12'h00C, 32'hB4);
    dump_ready_i = 1'b0;
    rd(12'h008, 32'h0000_0408);
    drain();
    rd(12'h008, 32'h4);
    // reset during flush with data queued
    for (int i = 0; i < 3; i++) wr(12'h00C, 32'hC0 + 32'(i));
    wr(12'h004, 32'h1);
    chk("pre_rst_flush", 32'(flush_stream_o), 32'd1);
    chk("pre_rst_valid", 32'(dump_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_flush", 32'(flush_stream_o), 32'd0);
    chk("arst_valid", 32'(dump_valid_o), 32'd0);
    chk("arst_data", dump_data_o, 32'd0);
    chk("arst_trace", 32'(trace_enable_o), 32'd0);
    chk("arst_filter_hi1", filter_hi_o[1], 32'd0);
    cyc();
    #3 rst_ni = 1'b1;
    cyc();
    chk("post_rst_flush", 32'(flush_stream_o), 32'd0);
    rd(12'h008, 32'h4);
    rd(12'h000, 32'h0);
    cyc();
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    chk("dump_queue_empty", 32'(dump_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trdb_regfile.md
TRDB_REGFILE -- requirements
Module: trdb_regfile

Interface
REQ-001 Parameter APB_ADDR_WIDTH, 12, peripheral address width in bits.
REQ-002 Parameter NUM_FILTERS, 2, number of address-range filter pairs, range 1..8.
REQ-003 Parameter DUMP_DEPTH, 4, dump FIFO entries, power of two, at least 2.
REQ-004 clk_i  in  1  clock, rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 per_valid_i / per_we_i  in  1 / 1  access request / write-not-read.
REQ-007 per_addr_i  in  APB_ADDR_WIDTH  byte address.
REQ-008 per_wdata_i / per_rdata_o  in / out  32 / 32  write data / read data.
REQ-009 per_ready_o  out  1  access accepted.
REQ-010 trace_enable_o  out  1  global trace enable, CFG[0].
REQ-011 filter_en_o  out  NUM_FILTERS  per-filter enable, CFG[8+i].
REQ-012 filter_lo_o / filter_hi_o  out  NUM_FILTERS x 32  filter bounds.
REQ-013 flush_stream_o / flush_confirm_i  out / in  1 / 1  flush request / flush complete.
REQ-014 dump_data_o / dump_valid_o / dump_ready_i  out / out / in  32 / 1 / 1  dump stream.

Function
REQ-015 Register map: CFG 0x00 RW; CTRL 0x04; STATUS 0x08; DUMP 0x0C WO; FILTER_LO[i] at 0x10+8i RW; FILTER_HI[i] at 0x14+8i RW.
REQ-016 Decode uses per_addr_i[APB_ADDR_WIDTH-1:2]; per_addr_i[1:0] is ignored.
REQ-017 Unmapped or write-only reads return 0; unmapped writes have no effect; no error signalling.
REQ-018 per_ready_o is tied to 1; read data is combinational in the same cycle as per_valid_i & ~per_we_i, and 0 otherwise.
REQ-019 Register writes take effect on the clock edge ending the access cycle.
REQ-020 Flush FSM has two states, IDLE and FLUSH; flush_stream_o = (state == FLUSH).
REQ-021 IDLE -> FLUSH on a CTRL write with wdata[0]=1; in FLUSH, further CTRL writes are ignored.
REQ-022 FLUSH -> IDLE on the first cycle with flush_confirm_i=1; flush_confirm_i is ignored in IDLE.
REQ-023 CTRL read returns {31'b0, flush busy}.
REQ-024 DUMP write pushes wdata into the FIFO; dump_data_o is the FIFO head; dump_valid_o = not empty.
REQ-025 Pop occurs when dump_valid_o & dump_ready_i.
REQ-026 A push while full with no pop in the same cycle is dropped and sets sticky STATUS[1] overflow.
REQ-027 A push while full with a simultaneous pop is accepted, and the count stays at DUMP_DEPTH.
REQ-028 A push and pop while non-empty leave the count unchanged; FIFO pointers wrap modulo DUMP_DEPTH.
REQ-029 STATUS read returns [0] flush busy, [1] overflow, [2] fifo empty, [3] fifo full, [15:8] fifo count, all other bits 0.
REQ-030 A STATUS write with wdata[1]=1 clears overflow; if an overflow event occurs in the same cycle, set wins.
REQ-031 STATUS bits other than overflow are read-only.

Reset
REQ-032 On rst_ni low, asynchronously: CFG=0, all filters=0, FSM=IDLE, FIFO empty with pointers 0, overflow=0.
REQ-033 During reset, all outputs are 0 except per_ready_o=1.
REQ-034 A reset asserted during FLUSH aborts the flush with no confirm required.
REQ-035 A reset discards FIFO contents.

Structure
REQ-036 Register offsets, CFG/STATUS bit indices and the flush-state enum belong in trdb_pkg.
REQ-037 The dump FIFO is one sub-module, trdb_fifo, parametrised by DATA_WIDTH and DEPTH, with push/pop/full/empty/count ports.

Verification
REQ-038 Write CFG=0x0000_0301, then read CFG -> 0x0000_0301; trace_enable_o=1; filter_en_o=2'b11.
REQ-039 Write FILTER_LO[1]=0x8000_0000 and FILTER_HI[1]=0x8000_FFFF -> filter_lo_o[1] and filter_hi_o[1] match; read back matches; reads of 0x40 -> 0.
REQ-040 Write CTRL=1 -> flush_stream_o=1 next cycle; write CTRL=1 again -> no change; pulse flush_confirm_i -> flush_stream_o=0 next cycle; STATUS[0]=0.
REQ-041 With dump_ready_i=0, write DUMP 5 times (0xA0..0xA4) -> STATUS full=1, overflow=1, count=4; then dump_ready_i=1 -> pops 0xA0..0xA3 in order; empty=1.
REQ-042 Fill FIFO to full, then DUMP write with dump_ready_i=1 in the same cycle -> no overflow, count=4, last word delivered after the others.
REQ-043 Assert rst_ni low mid-FLUSH with 3 FIFO entries -> flush_stream_o=0, dump_valid_o=0, STATUS=0x0000_0004 after release.
